// File: rtl/stage4_mem.sv
// Memory stage: drives a variable-latency data-memory handshake and holds the MEM/WB
// pipeline register, stalling upstream while an access is outstanding.
module stage4_mem #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        RegWrite_i,
   input  logic        MemtoReg_i,
   input  logic        Memory_write_i,
   input  logic        Memory_read_i,
   input  logic [31:0] Data1_i,
   input  logic [31:0] mux7_output_data_i,
   input  logic [4:0]  RDaddr_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic        RegWrite_o,
   output logic        MemtoReg_o,
   output logic [31:0] ReadData_o,
   output logic [31:0] ALUResult_o,
   output logic [4:0]  RDaddr_o,
   output logic        err_o
);

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        regwrite_q, regwrite_d;
   logic        memtoreg_q, memtoreg_d;
   logic [31:0] readdata_q, readdata_d;
   logic [31:0] aluresult_q, aluresult_d;
   logic [4:0]  rdaddr_q, rdaddr_d;
   logic        err_q, err_d;

   logic access, aligned, misalign, timeout, load_ack, store_acc;

   assign access    = Memory_read_i | Memory_write_i;
   assign aligned   = (Data1_i[1:0] == 2'b00);
   assign misalign  = access & ~aligned;
   assign store_acc = Memory_write_i;

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (access && aligned && !mem_ack_i) begin
               state_d = StWait;
               cnt_d   = 8'd0;
            end
         end
         StWait: begin
            if (mem_ack_i || timeout) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs; reset forces the request low even with live inputs.
   always_comb begin
      mem_req_o   = 1'b0;
      timeout     = 1'b0;
      if (rst_i) begin
         unique case (state_q)
            StIdle: mem_req_o = access & aligned;
            StWait: begin
               mem_req_o = 1'b1;
               timeout   = ~mem_ack_i & (cnt_q == CntLast);
            end
            default: mem_req_o = 1'b0;
         endcase
      end
      mem_we_o    = mem_req_o & Memory_write_i;
      mem_addr_o  = Data1_i;
      mem_wdata_o = mux7_output_data_i;
      stall_o     = mem_req_o & ~mem_ack_i & ~timeout;
      load_ack    = mem_req_o & mem_ack_i & ~Memory_write_i;
   end

   // MEM/WB next state
   always_comb begin
      regwrite_d  = regwrite_q;
      memtoreg_d  = memtoreg_q;
      readdata_d  = readdata_q;
      aluresult_d = aluresult_q;
      rdaddr_d    = rdaddr_q;
      err_d       = err_q | timeout | misalign;
      if (stall_o) begin
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
      end else begin
         regwrite_d  = RegWrite_i & ~timeout & ~misalign;
         memtoreg_d  = MemtoReg_i;
         aluresult_d = Data1_i;
         rdaddr_d    = RDaddr_i;
         if (timeout || misalign || (access && store_acc)) begin
            readdata_d = 32'd0;
         end else if (load_ack) begin
            readdata_d = mem_rdata_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         regwrite_q  <= 1'b0;
         memtoreg_q  <= 1'b0;
         readdata_q  <= 32'd0;
         aluresult_q <= 32'd0;
         rdaddr_q    <= 5'd0;
         err_q       <= 1'b0;
      end else begin
         regwrite_q  <= regwrite_d;
         memtoreg_q  <= memtoreg_d;
         readdata_q  <= readdata_d;
         aluresult_q <= aluresult_d;
         rdaddr_q    <= rdaddr_d;
         err_q       <= err_d;
      end
   end

   assign RegWrite_o  = regwrite_q;
   assign MemtoReg_o  = memtoreg_q;
   assign ReadData_o  = readdata_q;
   assign ALUResult_o = aluresult_q;
   assign RDaddr_o    = rdaddr_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_stage4_mem.sv
// Directed bench for stage4_mem (TIMEOUT = 4): single-cycle vector table plus
// hand-written wait-state, timeout, misalignment and reset sequences.
module tb_stage4_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rw, m2r, wr, rd, ack;
   logic [31:0] addr, wdata, rdata;
   logic [4:0]  rda;
   logic        mem_req_o, mem_we_o, stall_o, RegWrite_o, MemtoReg_o, err_o;
   logic [31:0] mem_addr_o, mem_wdata_o, ReadData_o, ALUResult_o;
   logic [4:0]  RDaddr_o;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic        rd, wr, rw, m2r;
      logic [31:0] addr, wdata;
      logic [4:0]  rda;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req, e_we, e_rw, e_m2r;
      logic [31:0] e_rd;
      logic        e_err;
   } vec_t;

   stage4_mem #(.TIMEOUT(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .RegWrite_i(rw), .MemtoReg_i(m2r), .Memory_write_i(wr), .Memory_read_i(rd),
      .Data1_i(addr), .mux7_output_data_i(wdata), .RDaddr_i(rda),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(ack), .mem_rdata_i(rdata),
      .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
      .ReadData_o(ReadData_o), .ALUResult_o(ALUResult_o), .RDaddr_o(RDaddr_o),
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, need $finish)");
      $fatal(1);
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %b, expected %b", name, act, exp);
      else n_pass++;
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else n_pass++;
   endtask

   function automatic vec_t mk(logic r, logic w, logic g, logic m, logic [31:0] a,
                               logic [31:0] d, logic [4:0] ra, logic k, logic [31:0] q,
                               logic ereq, logic erw, logic [31:0] erd, logic eerr);
      vec_t v;
      v.rd = r; v.wr = w; v.rw = g; v.m2r = m; v.addr = a; v.wdata = d; v.rda = ra;
      v.ack = k; v.rdata = q; v.e_req = ereq; v.e_we = ereq & w; v.e_rw = erw;
      v.e_m2r = m; v.e_rd = erd; v.e_err = eerr;
      return v;
   endfunction

   task automatic drive(input logic r, input logic w, input logic g, input logic m,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] ra,
                        input logic k, input logic [31:0] q);
      rd = r; wr = w; rw = g; m2r = m; addr = a; wdata = d; rda = ra; ack = k; rdata = q;
   endtask

   // One non-stalling cycle: comb checks before the edge, MEM/WB checks after it.
   task automatic apply_vec(input string tag, input vec_t v);
      drive(v.rd, v.wr, v.rw, v.m2r, v.addr, v.wdata, v.rda, v.ack, v.rdata);
      #2;
      chk1({tag, ".req"}, mem_req_o, v.e_req);
      chk1({tag, ".we"}, mem_we_o, v.e_we);
      chk1({tag, ".stall"}, stall_o, 1'b0);
      @(posedge clk); #1;
      chk1({tag, ".RegWrite"}, RegWrite_o, v.e_rw);
      chk1({tag, ".MemtoReg"}, MemtoReg_o, v.e_m2r);
      chk32({tag, ".ReadData"}, ReadData_o, v.e_rd);
      chk32({tag, ".ALUResult"}, ALUResult_o, v.addr);
      chk32({tag, ".RDaddr"}, {27'd0, RDaddr_o}, {27'd0, v.rda});
      chk1({tag, ".err"}, err_o, v.e_err);
   endtask

   vec_t vecs[6];

   initial begin
      // Ops completing in one cycle; ReadData holds across the non-memory entries.
      vecs[0] = mk(1, 0, 1, 1, 32'h100, 32'h0, 5'd5, 1, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 0);
      vecs[1] = mk(0, 0, 1, 0, 32'h55, 32'h0, 5'd7, 1, 32'h11111111, 0, 1, 32'hDEADBEEF, 0);
      vecs[2] = mk(0, 1, 0, 0, 32'h40, 32'hCAFE, 5'd0, 1, 32'h22222222, 1, 0, 32'h0, 0);
      vecs[3] = mk(1, 0, 1, 1, 32'h8, 32'h0, 5'd9, 1, 32'h0BADF00D, 1, 1, 32'h0BADF00D, 0);
      vecs[4] = mk(1, 1, 0, 0, 32'hC, 32'h9, 5'd3, 1, 32'h33333333, 1, 0, 32'h0, 0);
      vecs[5] = mk(0, 0, 1, 0, 32'h12345678, 32'h0, 5'd12, 0, 32'h44, 0, 1, 32'h0, 0);

      // Reset with random inputs over 3 edges
      for (int i = 0; i < 3; i++) begin
         drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom),
               $urandom, $urandom);
         @(posedge clk); #1;
      end
      chk1("rst.req", mem_req_o, 1'b0);
      chk1("rst.we", mem_we_o, 1'b0);
      chk1("rst.stall", stall_o, 1'b0);
      chk1("rst.RegWrite", RegWrite_o, 1'b0);
      chk1("rst.MemtoReg", MemtoReg_o, 1'b0);
      chk32("rst.ReadData", ReadData_o, 32'h0);
      chk32("rst.ALUResult", ALUResult_o, 32'h0);
      chk32("rst.RDaddr", {27'd0, RDaddr_o}, 32'h0);
      chk1("rst.err", err_o, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

      // Three-wait store, preceded by a load so held ReadData is visible in bubbles
      apply_vec("pre", mk(1, 0, 1, 1, 32'h60, 0, 5'd1, 1, 32'hA5A5A5A5, 1, 1, 32'hA5A5A5A5, 0));
      for (int c = 0; c < 4; c++) begin
         drive(0, 1, 1, 1, 32'h20, 32'h1234, 5'd10, c == 3, 32'h0);
         #2;
         chk1($sformatf("st3.req%0d", c), mem_req_o, 1'b1);
         chk1($sformatf("st3.we%0d", c), mem_we_o, 1'b1);
         chk32($sformatf("st3.wdata%0d", c), mem_wdata_o, 32'h1234);
         chk1($sformatf("st3.stall%0d", c), stall_o, c < 3);
         @(posedge clk); #1;
         chk1($sformatf("st3.RegWrite%0d", c), RegWrite_o, c == 3);
         chk1($sformatf("st3.MemtoReg%0d", c), MemtoReg_o, c == 3);
         chk32($sformatf("st3.ReadData%0d", c), ReadData_o,
               (c == 3) ? 32'h0 : 32'hA5A5A5A5);
      end
      chk32("st3.ALUResult", ALUResult_o, 32'h20);
      chk32("st3.RDaddr", {27'd0, RDaddr_o}, 32'd10);

      // Reset asserted mid-WAIT drops the request asynchronously
      drive(1, 0, 1, 1, 32'h200, 0, 5'd2, 0, 32'h0);
      @(posedge clk); #1;
      chk1("rstw.req_before", mem_req_o, 1'b1);
      chk1("rstw.stall_before", stall_o, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk1("rstw.req", mem_req_o, 1'b0);
      chk1("rstw.stall", stall_o, 1'b0);
      chk1("rstw.RegWrite", RegWrite_o, 1'b0);
      #3 rst = 1'b1;
      apply_vec("rstw.fresh",
                mk(1, 0, 1, 1, 32'h300, 0, 5'd4, 1, 32'h5A5A5A5A, 1, 1, 32'h5A5A5A5A, 0));

      // Timeout: TIMEOUT=4 gives 5 request cycles, 4 stalls
      for (int c = 0; c < 5; c++) begin
         drive(1, 0, 1, 1, 32'h400, 0, 5'd6, 0, 32'hFFFFFFFF);
         #2;
         chk1($sformatf("to.req%0d", c), mem_req_o, 1'b1);
         chk1($sformatf("to.stall%0d", c), stall_o, c < 4);
         @(posedge clk); #1;
         chk1($sformatf("to.RegWrite%0d", c), RegWrite_o, 1'b0);
         chk1($sformatf("to.err%0d", c), err_o, c == 4);
         chk32($sformatf("to.ReadData%0d", c), ReadData_o,
               (c == 4) ? 32'h0 : 32'h5A5A5A5A);
      end
      // Late ack with no request is ignored
      apply_vec("to.late", mk(0, 0, 1, 0, 32'h404, 0, 5'd2, 1, 32'hFFFFFFFF, 0, 1, 32'h0, 1));

      // Misaligned load after a fresh reset
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk1("mis.err_clr", err_o, 1'b0);
      apply_vec("mis.pre", mk(1, 0, 1, 1, 32'h104, 0, 5'd8, 1, 32'h77, 1, 1, 32'h77, 0));
      apply_vec("mis", mk(1, 0, 1, 1, 32'h103, 0, 5'd8, 1, 32'h88, 0, 0, 32'h0, 1));
      apply_vec("mis.sticky", mk(0, 0, 1, 0, 32'h0, 0, 5'd1, 0, 32'h0, 0, 1, 32'h0, 1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stage4_mem.md
# stage4_mem

Memory stage of the five-stage pipeline. It consumes the EX/MEM register outputs (control bits, ALU result used as the address, store data, destination register), performs the data-memory access over a variable-latency request/acknowledge interface, and holds the MEM/WB pipeline register that feeds write-back. While an access is outstanding it raises `stall_o` to freeze all upstream stages and inserts bubbles into MEM/WB. A bounded timeout and alignment check report faults through a sticky `err_o`.

## Interface
- `TIMEOUT`, default 15: maximum WAIT cycles before an access is force-completed (range 1..255).
- `clk_i  in  1  clock; all state updates on the rising edge`
- `rst_i  in  1  asynchronous, active-low reset`
- `RegWrite_i  in  1  EX/MEM register-write control`
- `MemtoReg_i  in  1  EX/MEM write-back select`
- `Memory_write_i  in  1  store request`
- `Memory_read_i  in  1  load request`
- `Data1_i  in  32  ALU result / byte address`
- `mux7_output_data_i  in  32  store data`
- `RDaddr_i  in  5  destination register`
- `mem_req_o  out  1  memory request, held until completion`
- `mem_we_o  out  1  1 = write, 0 = read; valid with mem_req_o`
- `mem_addr_o  out  32  equals Data1_i`
- `mem_wdata_o  out  32  equals mux7_output_data_i`
- `mem_ack_i  in  1  memory completion; ignored when mem_req_o = 0`
- `mem_rdata_i  in  32  load data, valid in the cycle mem_ack_i = 1`
- `stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM`
- `RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control`
- `ReadData_o  out  32  MEM/WB load data`
- `ALUResult_o  out  32  MEM/WB copy of Data1_i`
- `RDaddr_o  out  5  MEM/WB destination`
- `err_o  out  1  sticky fault flag`

## Operation
- `access = Memory_read_i | Memory_write_i`. Write has priority: if both are set, the access is a store and `ReadData_o` is loaded with 0.
- Misaligned access (`Data1_i[1:0] != 0` with access = 1):
  - No request is issued; `stall_o` = 0.
  - MEM/WB receives a bubble with `RegWrite_o` = 0.
  - `err_o` is set.
- FSM, two states:
  - IDLE: `mem_req_o = access & aligned`.
    - If `mem_ack_i` = 1 in the same cycle, the access completes with no stall.
    - Otherwise go to WAIT and clear `cnt` to 0.
  - WAIT: `mem_req_o` = 1.
    - On `mem_ack_i` = 1, complete and go to IDLE.
    - On `mem_ack_i` = 0 with `cnt == TIMEOUT-1`, time out: force completion, go to IDLE and set `err_o`.
    - Otherwise increment `cnt`.
- `cnt` is 8 bits wide and never wraps, because `TIMEOUT` is at most 255.
- `stall_o = mem_req_o & ~mem_ack_i & ~timeout`.
- MEM/WB update at each rising edge:
  - If `stall_o` = 1, load a bubble: `RegWrite_o` = 0, `MemtoReg_o` = 0, other fields unchanged.
  - Otherwise load `RegWrite_i`, `MemtoReg_i`, `Data1_i` and `RDaddr_i`.
  - `ReadData_o` takes `mem_rdata_i` on a load acknowledged this cycle; it takes 0 on a store, a timeout or a misaligned access; it holds for a non-memory instruction.
  - On timeout or misalignment, `RegWrite_o` is forced to 0.
- `err_o` is cleared only by reset.
- `mem_ack_i` while `mem_req_o` = 0, such as a late ack after a timeout, has no effect.

## Timing
- Reset (asynchronous, while `rst_i` = 0):
  - State = IDLE, `cnt` = 0, `err_o` = 0.
  - All MEM/WB outputs = 0.
  - `mem_req_o` and `stall_o` are forced to 0.
- Non-memory instruction: 1 cycle; MEM/WB is valid after the next edge.
- Access acknowledged N cycles after `mem_req_o` first rises (N = 0 means same cycle):
  - `stall_o` is high for N cycles.
  - N bubbles enter MEM/WB, then the real entry.
- Maximum request duration is `TIMEOUT+1` cycles: 1 in IDLE plus `TIMEOUT` in WAIT.
- Upstream inputs are held stable by `stall_o`. `mem_addr_o`, `mem_wdata_o` and `mem_we_o` are therefore stable for the whole request.
- Reset asserted mid-WAIT aborts the access immediately. After release, the stage restarts in IDLE.

## Test plan
- Reset: hold `rst_i` = 0 over 3 edges with random inputs -> all outputs 0, `mem_req_o` = 0, `stall_o` = 0.
- Zero-wait load:
  - Stimulus: `Memory_read_i` = 1, `Data1_i` = 0x100, `RDaddr_i` = 5, `RegWrite_i` = 1, `MemtoReg_i` = 1; `mem_ack_i` = 1 with `mem_rdata_i` = 0xDEADBEEF in the same cycle.
  - Response: `stall_o` stays 0; after the edge, `ReadData_o` = 0xDEADBEEF, `RDaddr_o` = 5, `RegWrite_o` = 1.
- Three-wait store:
  - Stimulus: `Memory_write_i` = 1, `Data1_i` = 0x20, `mux7_output_data_i` = 0x1234; `mem_ack_i` = 1 on the 4th request cycle.
  - Response: `mem_we_o` = 1 for 4 cycles; `stall_o` high for 3; 3 bubbles (`RegWrite_o` = 0), then the store entry with `ReadData_o` = 0.
- Timeout (`TIMEOUT` = 4): load with `mem_ack_i` held 0 -> `mem_req_o` high for 5 cycles and `stall_o` high for 4; after the 5th edge, `err_o` = 1, `RegWrite_o` = 0, `ReadData_o` = 0; a later ack is ignored.
- Misaligned load at `Data1_i` = 0x103 -> `mem_req_o` stays 0, `stall_o` stays 0, `err_o` = 1 after the edge, `RegWrite_o` = 0.
- Reset asserted during WAIT -> `mem_req_o` and `stall_o` drop asynchronously; after release, a fresh load with immediate ack completes normally.
